// File: rtl/bram_cfg_dp_if.sv
// Bus bundle for the bram_cfg_dp tile: write request, read request and read response.
// The master side issues requests; the slave side is the RAM tile.
interface bram_cfg_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [1:0]            rd_sel;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output wr_en, wr_addr, wr_sel, wr_data, rd_en, rd_addr, rd_sel,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_sel, wr_data, rd_en, rd_addr, rd_sel,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/bram_cfg_dp.sv
// Simple-dual-port block RAM tile with per-port aspect ratio, optional output register
// and, when BRAM_CLEAR_ON_RESET_EN is defined, a power-up clear sequencer.
module bram_cfg_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_wr_mode,
  input  logic [1:0]        cfg_rd_mode,
  input  logic              cfg_out_reg,
  bram_cfg_dp_if.slave      bus
);

  localparam int LANE_W = DATA_WIDTH / 4;
  localparam int HALF_W = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  // NOTE: the storage array has no reset; only the optional clear sequencer initialises it.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_addr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic                  wr_accept;
  logic                  rd_accept;
  logic [3:0]            wr_lane_en;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [3:0]            mem_lane_en;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign wr_accept = bus.wr_en & ~busy & (cfg_wr_mode != MODE_OFF);
  assign rd_accept = bus.rd_en & ~busy;

  // Narrow writes replicate the source slice across lanes; the lane mask picks the target.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    wr_lane_en = '0;
    wr_word    = bus.wr_data;
    case (mode_e'(cfg_wr_mode))
      MODE_FULL: wr_lane_en = 4'b1111;
      MODE_HALF: begin
        wr_lane_en = bus.wr_sel[0] ? 4'b1100 : 4'b0011;
        wr_word    = {2{bus.wr_data[HALF_W-1:0]}};
      end
      MODE_QUARTER: begin
        wr_lane_en = 4'b0001 << bus.wr_sel;
        wr_word    = {4{bus.wr_data[LANE_W-1:0]}};
      end
      default: wr_lane_en = '0;
    endcase
    if (!wr_accept) wr_lane_en = '0;
  end

  assign mem_lane_en = clr_we ? 4'b1111 : wr_lane_en;
  assign mem_waddr   = clr_we ? clr_addr : bus.wr_addr;
  assign mem_wdata   = clr_we ? '0 : wr_word;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (mem_lane_en[l]) mem[mem_waddr][l*LANE_W +: LANE_W] <= mem_wdata[l*LANE_W +: LANE_W];
    end
  end

  // Read pipeline: stage 1 holds the raw word and its sub-word select, stage 2 the muxed result.
  logic [DATA_WIDTH-1:0] rd_word_q, rd_word_d;
  logic [1:0]            rd_sel_q, rd_sel_d;
  logic                  rd_v1_q, rd_v1_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_v2_q, rd_v2_d;
  logic [DATA_WIDTH-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (mode_e'(cfg_rd_mode))
      MODE_HALF:    rd_mux[HALF_W-1:0] = rd_sel_q[0] ? rd_word_q[DATA_WIDTH-1:HALF_W]
                                                     : rd_word_q[HALF_W-1:0];
      MODE_QUARTER: rd_mux[LANE_W-1:0] = rd_word_q[rd_sel_q*LANE_W +: LANE_W];
      default:      rd_mux             = rd_word_q;
    endcase
  end

  // The array is sampled before this edge's write lands, giving read-first collisions.
  always_comb begin
    rd_word_d = rd_accept ? mem[bus.rd_addr] : rd_word_q;
    rd_sel_d  = rd_accept ? bus.rd_sel : rd_sel_q;
    rd_v1_d   = rd_accept;
    rd_data_d = rd_v1_q ? rd_mux : rd_data_q;
    rd_v2_d   = rd_v1_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      rd_word_q <= '0;
      rd_sel_q  <= '0;
      rd_v1_q   <= 1'b0;
      rd_data_q <= '0;
      rd_v2_q   <= 1'b0;
    end else begin
      rd_word_q <= rd_word_d;
      rd_sel_q  <= rd_sel_d;
      rd_v1_q   <= rd_v1_d;
      rd_data_q <= rd_data_d;
      rd_v2_q   <= rd_v2_d;
    end
  end

  assign bus.rd_data  = cfg_out_reg ? rd_data_q : rd_mux;
  assign bus.rd_valid = cfg_out_reg ? rd_v2_q : rd_v1_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_bram_cfg_dp.sv
// Self-checking bench for bram_cfg_dp: directed scenarios plus randomized traffic
// compared against a word-array reference model with a latency-tagged result queue.
module tb_bram_cfg_dp;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_wr_mode = 2'd0;
  logic [1:0] cfg_rd_mode = 2'd0;
  logic       cfg_out_reg = 1'b0;

  bram_cfg_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_cfg_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr_mode (cfg_wr_mode),
    .cfg_rd_mode (cfg_rd_mode),
    .cfg_out_reg (cfg_out_reg),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int clr_left = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_d = '0;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;
  pend_t pend_q[$];

  function automatic logic [DW-1:0] model_read(input logic [DW-1:0] word, input logic [1:0] mode,
                                               input logic [1:0] sel);
    case (mode)
      2'd1:    return (word >> (16 * sel[0])) & 32'h0000_FFFF;
      2'd2:    return (word >> (8 * sel)) & 32'h0000_00FF;
      default: return word;
    endcase
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [1:0] mode,
                             input logic [1:0] sel, input logic [DW-1:0] data);
    logic [DW-1:0] w;
    w = model_mem[addr];
    case (mode)
      2'd0:    w = data;
      2'd1:    w[16*sel[0] +: 16] = data[15:0];
      2'd2:    w[8*sel +: 8] = data[7:0];
      default: w = model_mem[addr];
    endcase
    model_mem[addr] = w;
  endtask

  // One clock with rst low; returns what the outputs must show just after the edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [1:0] ws,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic [1:0] rs, output logic ev, output logic [DW-1:0] ed,
                      output logic eb);
    bit    acc;
    pend_t p;
    rst         = 1'b0;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_sel  = ws;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    bus.rd_sel  = rs;
    @(posedge clk);
    cycle++;
    acc = (clr_left == 0);
    if (clr_left > 0) clr_left--;
    if (acc && re) begin
      p.due  = cycle + (cfg_out_reg ? 1 : 0);
      p.data = model_read(model_mem[ra], cfg_rd_mode, rs);
      pend_q.push_back(p);
    end
    if (acc && we) model_write(wa, cfg_wr_mode, ws, wd);
    #1;
    eb = (clr_left > 0);
    if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
      ev     = 1'b1;
      ed     = pend_q[0].data;
      last_d = ed;
      void'(pend_q.pop_front());
    end else begin
      ev = 1'b0;
      ed = last_d;
    end
  endtask

  task automatic rst_cycle(input logic re);
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = re;
    bus.rd_addr = AW'($urandom_range(DEPTH - 1, 0));
    @(posedge clk);
    cycle++;
    pend_q.delete();
    last_d = '0;
`ifdef BRAM_CLEAR_ON_RESET_EN
    clr_left = DEPTH;
    foreach (model_mem[i]) model_mem[i] = '0;
`endif
    #1;
  endtask

  task automatic drain();
    logic ev, eb;
    logic [DW-1:0] ed;
    while (clr_left > 0 || pend_q.size() > 0) step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
  endtask

  // Read-mode changes go through reset so the held output is well defined afterwards.
  task automatic set_cfg(input logic [1:0] wm, input logic [1:0] rm, input logic oreg);
    drain();
    if (rm != cfg_rd_mode) begin
      rst_cycle(1'b0);
      cfg_rd_mode = rm;
    end
    cfg_wr_mode = wm;
    cfg_out_reg = oreg;
    drain();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_cycle(1'(i));
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
        n_err++;
        $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", bus.rd_valid, bus.rd_data);
      end
      n_cmp++;
      if (bus.busy !== (clr_left > 0)) begin
        n_err++;
        $display("FAIL reset_busy: got %b want %b", bus.busy, clr_left > 0);
      end
    end
  endtask

  task automatic test_full_rw();
    logic ev, eb;
    logic [DW-1:0] ed;
    set_cfg(2'd0, 2'd0, 1'b0);
    step(1, 8'h12, 0, 32'hDEAD_BEEF, 0, 0, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full_nowrite_valid: got %b want 0", bus.rd_valid);
    end
    step(0, 0, 0, 0, 1, 8'h12, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL full_read: got v=%b d=%h want v=1 d=deadbeef", bus.rd_valid, bus.rd_data);
    end
    step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL full_hold: got v=%b d=%h want v=0 d=deadbeef", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_lanes();
    logic ev, eb;
    logic [DW-1:0] ed;
    logic [DW-1:0] want [5] = '{32'h11AA_3344, 32'h0000_11AA, 32'h0000_3344, 32'h0000_BEEF,
                                32'h0000_00BE};
    logic [DW-1:0] got [5];
    set_cfg(2'd0, 2'd0, 1'b0);
    step(1, 8'h20, 0, 32'h1122_3344, 0, 0, 0, ev, ed, eb);
    cfg_wr_mode = 2'd2;
    step(1, 8'h20, 2, {24'($urandom), 8'hAA}, 0, 0, 0, ev, ed, eb);
    step(0, 0, 0, 0, 1, 8'h20, 2'($urandom_range(3, 0)), ev, ed, eb);
    got[0] = bus.rd_data;
    cfg_rd_mode = 2'd1;
    step(0, 0, 0, 0, 1, 8'h20, 1, ev, ed, eb);
    got[1] = bus.rd_data;
    step(0, 0, 0, 0, 1, 8'h20, 0, ev, ed, eb);
    got[2] = bus.rd_data;
    cfg_wr_mode = 2'd1;
    step(1, 8'h20, 1, {16'($urandom), 16'hBEEF}, 0, 0, 0, ev, ed, eb);
    step(0, 0, 0, 0, 1, 8'h20, 1, ev, ed, eb);
    got[3] = bus.rd_data;
    cfg_rd_mode = 2'd2;
    step(0, 0, 0, 0, 1, 8'h20, 3, ev, ed, eb);
    got[4] = bus.rd_data;
    cfg_rd_mode = 2'd0;
    step(0, 0, 0, 0, 1, 8'h20, 0, ev, ed, eb);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin
        n_err++;
        $display("FAIL lane_read%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    n_cmp++;
    if (bus.rd_data !== 32'hBEEF_3344) begin
      n_err++;
      $display("FAIL lane_full_after_half: got %h want beef3344", bus.rd_data);
    end
  endtask

  task automatic test_out_reg_burst();
    logic ev, eb;
    logic [DW-1:0] ed;
    logic [DW-1:0] d [3];
    logic          want_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] want_d [5];
    set_cfg(2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      step(1, AW'(i), 0, d[i], 0, 0, 0, ev, ed, eb);
    end
    drain();
    want_d = '{last_d, d[0], d[1], d[2], d[2]};
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, (i < 3), AW'(i), 0, ev, ed, eb);
      n_cmp++;
      if (bus.rd_valid !== want_v[i] || bus.rd_data !== want_d[i]) begin
        n_err++;
        $display("FAIL outreg_burst%0d: got v=%b d=%h want v=%b d=%h", i, bus.rd_valid,
                 bus.rd_data, want_v[i], want_d[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic ev, eb;
    logic [DW-1:0] ed;
    set_cfg(2'd0, 2'd0, 1'b0);
    step(1, 8'h05, 0, 32'h1, 0, 0, 0, ev, ed, eb);
    step(1, 8'h05, 0, 32'h2, 1, 8'h05, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1) begin
      n_err++;
      $display("FAIL collision_old: got v=%b d=%h want v=1 d=1", bus.rd_valid, bus.rd_data);
    end
    step(0, 0, 0, 0, 1, 8'h05, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h2) begin
      n_err++;
      $display("FAIL collision_new: got v=%b d=%h want v=1 d=2", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_wr_disabled();
    logic ev, eb;
    logic [DW-1:0] ed;
    set_cfg(2'd0, 2'd0, 1'b0);
    step(1, 8'h07, 0, 32'h1234_5678, 0, 0, 0, ev, ed, eb);
    set_cfg(2'd3, 2'd0, 1'b0);
    step(1, 8'h07, 0, 32'h55, 0, 0, 0, ev, ed, eb);
    step(0, 0, 0, 0, 1, 8'h07, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL wr_disabled: got v=%b d=%h want v=1 d=12345678", bus.rd_valid, bus.rd_data);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) rst_cycle(1'b1);
      else step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
        n_err++;
        $display("FAIL rd_in_reset%0d: got v=%b d=%h want v=0 d=0", i, bus.rd_valid, bus.rd_data);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic ev, eb;
    logic [DW-1:0] ed;
    set_cfg(2'd0, 2'd0, 1'b1);
    step(0, 0, 0, 0, 1, 8'h07, 0, ev, ed, eb);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) rst_cycle(1'b0);
      else step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
        n_err++;
        $display("FAIL reset_mid_read%0d: got v=%b d=%h want v=0 d=0", i, bus.rd_valid,
                 bus.rd_data);
      end
    end
  endtask

  task automatic test_random();
    logic ev, eb, we, re;
    logic [DW-1:0] ed, wd;
    logic [AW-1:0] wa, ra;
    logic [1:0]    ws, rs;
    set_cfg(2'd0, 2'd0, 1'b0);
    for (int a = 0; a < 16; a++) step(1, AW'(a), 0, $urandom, 0, 0, 0, ev, ed, eb);
    for (int blk = 0; blk < 6; blk++) begin
      set_cfg(2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      for (int i = 0; i < 50; i++) begin
        we = 1'($urandom_range(1, 0));
        re = 1'($urandom_range(1, 0));
        wa = AW'($urandom_range(15, 0));
        ra = AW'($urandom_range(15, 0));
        ws = 2'($urandom_range(3, 0));
        rs = 2'($urandom_range(3, 0));
        wd = $urandom;
        step(we, wa, ws, wd, re, ra, rs, ev, ed, eb);
        n_cmp++;
        if (bus.rd_valid !== ev || bus.rd_data !== ed || bus.busy !== eb) begin
          n_err++;
          $display("FAIL random b%0d c%0d: got v=%b d=%h busy=%b want v=%b d=%h busy=%b", blk, i,
                   bus.rd_valid, bus.rd_data, bus.busy, ev, ed, eb);
        end
      end
    end
  endtask

`ifdef BRAM_CLEAR_ON_RESET_EN
  task automatic test_clear();
    logic ev, eb;
    logic [DW-1:0] ed;
    int n_busy;
    int guard;
    set_cfg(2'd0, 2'd0, 1'b0);
    step(1, 8'h40, 0, 32'hFFFF_FFFF, 0, 0, 0, ev, ed, eb);
    rst_cycle(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'h40, 0, $urandom, 1, 8'h40, 0, ev, ed, eb);
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.busy !== (i < DEPTH - 1)) begin
        n_err++;
        $display("FAIL clear_busy%0d: got v=%b busy=%b want v=0 busy=%b", i, bus.rd_valid,
                 bus.busy, i < DEPTH - 1);
      end
    end
    step(0, 0, 0, 0, 1, 8'h40, 0, ev, ed, eb);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL clear_result: got v=%b d=%h want v=1 d=0", bus.rd_valid, bus.rd_data);
    end
    rst_cycle(1'b0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
    rst_cycle(1'b0);
    n_busy = 0;
    guard  = 0;
    while (bus.busy === 1'b1 && guard < 600) begin
      n_busy++;
      guard++;
      step(0, 0, 0, 0, 0, 0, 0, ev, ed, eb);
    end
    n_cmp++;
    if (n_busy != DEPTH) begin
      n_err++;
      $display("FAIL clear_restart_len: got %0d busy cycles want %0d", n_busy, DEPTH);
    end
    drain();
  endtask
`endif

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_sel  = '0;
    test_reset();
    test_full_rw();
    test_lanes();
    test_out_reg_burst();
    test_collision();
    test_wr_disabled();
    test_reset_mid_read();
    test_random();
`ifdef BRAM_CLEAR_ON_RESET_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
